// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-controller bundle: pipeline-side hazard inputs and stage control outputs.
// master = pipeline datapath side, slave = pipeline_hazard_controller.
interface pipeline_hazard_controller_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
);
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_uses_rt;
  logic [REG_AW-1:0] idex_rt;
  logic              idex_mem_read;
  logic              branch_taken;
  logic              dmem_req;
  logic              dmem_ready;

  logic              pc_write;
  logic              ifid_write;
  logic              ifid_flush;
  logic              idex_write;
  logic              idex_bubble;
  logic              exmem_hold;
  logic              mem_err;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rt, idex_rt, idex_mem_read,
           branch_taken, dmem_req, dmem_ready,
    input  pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
           exmem_hold, mem_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, idex_rt, idex_mem_read,
           branch_taken, dmem_req, dmem_ready,
    output pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
           exmem_hold, mem_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// 5-stage pipeline hazard sequencer: load-use stall, taken-branch flush, data-memory wait/timeout.
// Optional performance counters built only when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_controller #(
  parameter int unsigned REG_AW       = 5,
  parameter int unsigned BR_FLUSH_CYC = 1,
  parameter int unsigned MEM_TIMEOUT  = 255,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  pipeline_hazard_controller_if.slave   bus
);

  typedef enum logic [1:0] {RUN, FLUSH, MEM_WAIT, ERROR} state_t;

  localparam logic [15:0] TIMEOUT = 16'(MEM_TIMEOUT);
  localparam logic [1:0]  BR_M1   = 2'(BR_FLUSH_CYC - 1);

  state_t      state_q, state_d;
  logic [1:0]  fcnt_q, fcnt_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic        saved_flush_q, saved_flush_d;
  logic        mem_err_q, mem_err_d;

  logic [REG_AW-1:0] rs, rt, xrt;
  logic mem_wait, lu;
  logic pc_we, ifid_we, ifid_fl, idex_we, idex_bub, hold;

  assign rs  = bus.id_rs;
  assign rt  = bus.id_rt;
  assign xrt = bus.idex_rt;

  assign mem_wait = bus.dmem_req && !bus.dmem_ready;
  assign lu = bus.idex_mem_read && (xrt != '0) &&
              ((xrt == rs) || (bus.id_uses_rt && (xrt == rt)));

  // Outputs forced to their reset values while rst_n is low, independent of inputs.
  always_comb begin
    pc_we    = 1'b1;
    ifid_we  = 1'b1;
    idex_we  = 1'b1;
    ifid_fl  = 1'b0;
    idex_bub = 1'b0;
    hold     = 1'b0;
    if (rst_n) begin
      if (state_q == ERROR || mem_wait) begin
        pc_we   = 1'b0;
        ifid_we = 1'b0;
        idex_we = 1'b0;
        hold    = 1'b1;
      end else if (state_q != MEM_WAIT) begin
        if (bus.branch_taken || state_q == FLUSH) begin
          ifid_fl  = 1'b1;
          idex_bub = 1'b1;
        end else if (lu) begin
          pc_we    = 1'b0;
          ifid_we  = 1'b0;
          idex_bub = 1'b1;
        end
      end
    end
  end

  // The flush count is left untouched across MEM_WAIT, so it doubles as the saved remaining count.
  // The cycle the access completes just releases the pipeline; the flush resumes on the next one.
  always_comb begin
    state_d       = state_q;
    fcnt_d        = fcnt_q;
    wcnt_d        = wcnt_q;
    saved_flush_d = saved_flush_q;
    mem_err_d     = mem_err_q;
    unique case (state_q)
      RUN, FLUSH: begin
        if (mem_wait) begin
          state_d       = MEM_WAIT;
          saved_flush_d = (state_q == FLUSH);
          wcnt_d        = 16'd1;
        end else if (bus.branch_taken) begin
          fcnt_d  = BR_M1;
          state_d = (BR_M1 != 2'd0) ? FLUSH : RUN;
        end else if (state_q == FLUSH) begin
          fcnt_d = fcnt_q - 2'd1;
          if (fcnt_q == 2'd1) state_d = RUN;
        end
      end
      MEM_WAIT: begin
        if (mem_wait) begin
          if (wcnt_q == TIMEOUT) begin
            state_d   = ERROR;
            mem_err_d = 1'b1;
          end else begin
            wcnt_d = wcnt_q + 16'd1;
          end
        end else begin
          wcnt_d  = '0;
          state_d = saved_flush_q ? FLUSH : RUN;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      fcnt_q        <= '0;
      wcnt_q        <= '0;
      saved_flush_q <= 1'b0;
      mem_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      fcnt_q        <= fcnt_d;
      wcnt_q        <= wcnt_d;
      saved_flush_q <= saved_flush_d;
      mem_err_q     <= mem_err_d;
    end
  end

  assign bus.pc_write    = pc_we;
  assign bus.ifid_write  = ifid_we;
  assign bus.ifid_flush  = ifid_fl;
  assign bus.idex_write  = idex_we;
  assign bus.idex_bubble = idex_bub;
  assign bus.exmem_hold  = hold;
  assign bus.mem_err     = mem_err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             stall_ev;

  assign stall_ev = (!pc_we && idex_bub) || (hold && (state_q != ERROR));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_ev && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (ifid_fl && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
`else
  assign bus.stall_cnt = {CNT_W{1'b0}};
  assign bus.flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: two instances (BR_FLUSH_CYC 2 and 3) driven in lockstep,
// checked every cycle against a behavioural model plus directed literal expectations.
module tb_pipeline_hazard_controller;

`ifdef HAZARD_PERF_CNT_EN
  localparam int unsigned PERF = 1;
`else
  localparam int unsigned PERF = 0;
`endif
  localparam int unsigned TO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] id_rs = '0, id_rt = '0, idex_rt = '0;
  logic id_uses_rt = 1'b0, idex_mem_read = 1'b0, branch_taken = 1'b0;
  logic dmem_req = 1'b0, dmem_ready = 1'b0;

  pipeline_hazard_controller_if #(.REG_AW(5), .CNT_W(16)) ifa ();
  pipeline_hazard_controller_if #(.REG_AW(5), .CNT_W(4))  ifb ();

  assign ifa.id_rs = id_rs;           assign ifb.id_rs = id_rs;
  assign ifa.id_rt = id_rt;           assign ifb.id_rt = id_rt;
  assign ifa.id_uses_rt = id_uses_rt; assign ifb.id_uses_rt = id_uses_rt;
  assign ifa.idex_rt = idex_rt;       assign ifb.idex_rt = idex_rt;
  assign ifa.idex_mem_read = idex_mem_read; assign ifb.idex_mem_read = idex_mem_read;
  assign ifa.branch_taken = branch_taken;   assign ifb.branch_taken = branch_taken;
  assign ifa.dmem_req = dmem_req;     assign ifb.dmem_req = dmem_req;
  assign ifa.dmem_ready = dmem_ready; assign ifb.dmem_ready = dmem_ready;

  pipeline_hazard_controller #(.REG_AW(5), .BR_FLUSH_CYC(2), .MEM_TIMEOUT(TO), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa));
  pipeline_hazard_controller #(.REG_AW(5), .BR_FLUSH_CYC(3), .MEM_TIMEOUT(TO), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb));

  // {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_hold, mem_err}
  logic [6:0]  got_ctl [2];
  logic [15:0] got_st [2], got_fl [2];
  assign got_ctl[0] = {ifa.pc_write, ifa.ifid_write, ifa.ifid_flush, ifa.idex_write,
                       ifa.idex_bubble, ifa.exmem_hold, ifa.mem_err};
  assign got_ctl[1] = {ifb.pc_write, ifb.ifid_write, ifb.ifid_flush, ifb.idex_write,
                       ifb.idex_bubble, ifb.exmem_hold, ifb.mem_err};
  assign got_st[0] = ifa.stall_cnt;
  assign got_fl[0] = ifa.flush_cnt;
  assign got_st[1] = {12'b0, ifb.stall_cnt};
  assign got_fl[1] = {12'b0, ifb.flush_cnt};

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", nm, $time, got, exp);
    end
  endtask

  // Model: remaining flush cycles, wait length, sticky error, saturating event tallies.
  int unsigned br_cyc [2] = '{2, 3};
  int unsigned cmax [2]   = '{65535, 15};
  bit          m_err [2], m_wait [2];
  int unsigned m_wlen [2], m_frem [2], m_stall [2], m_flush [2];

  always @(negedge clk) begin : model_cmp
    logic [6:0] e;
    bit mw, lu;
    mw = dmem_req && !dmem_ready;
    lu = idex_mem_read && (idex_rt != 5'd0) &&
         ((idex_rt == id_rs) || (id_uses_rt && (idex_rt == id_rt)));
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_err[k] = 0; m_wait[k] = 0; m_wlen[k] = 0; m_frem[k] = 0;
        m_stall[k] = 0; m_flush[k] = 0;
      end
      chk($sformatf("stall_cnt[%0d]", k), {16'b0, got_st[k]}, m_stall[k]);
      chk($sformatf("flush_cnt[%0d]", k), {16'b0, got_fl[k]}, m_flush[k]);
      if (!rst_n) begin
        e = 7'b1101000;
      end else if (m_err[k]) begin
        e = 7'b0000011;
      end else if (mw) begin
        e = 7'b0000010;
        if (PERF != 0 && m_stall[k] < cmax[k]) m_stall[k]++;
        if (!m_wait[k]) begin
          m_wait[k] = 1; m_wlen[k] = 1;
        end else if (m_wlen[k] == TO) begin
          m_err[k] = 1;
        end else begin
          m_wlen[k]++;
        end
      end else if (m_wait[k]) begin
        e = 7'b1101000;
        m_wait[k] = 0; m_wlen[k] = 0;
      end else if (branch_taken || m_frem[k] > 0) begin
        e = 7'b1111100;
        m_frem[k] = branch_taken ? br_cyc[k] - 1 : m_frem[k] - 1;
        if (PERF != 0 && m_flush[k] < cmax[k]) m_flush[k]++;
      end else if (lu) begin
        e = 7'b0001100;
        if (PERF != 0 && m_stall[k] < cmax[k]) m_stall[k]++;
      end else begin
        e = 7'b1101000;
      end
      chk($sformatf("ctl[%0d]", k), {25'b0, got_ctl[k]}, {25'b0, e});
    end
  end

  task automatic apply(input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                       input logic [4:0] xrt, input logic mr, input logic br,
                       input logic rq, input logic rd);
    @(posedge clk);
    #1;
    id_rs = rs; id_rt = rt; id_uses_rt = ur; idex_rt = xrt;
    idex_mem_read = mr; branch_taken = br; dmem_req = rq; dmem_ready = rd;
    #2;
  endtask

  task automatic idle();
    apply(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic reset_now();
    rst_n = 1'b0;
    #1;
    chk("rst_pc_write", {31'b0, ifb.pc_write}, 32'd1);
    chk("rst_ifid_flush", {31'b0, ifb.ifid_flush}, 32'd0);
    chk("rst_idex_bubble", {31'b0, ifb.idex_bubble}, 32'd0);
    chk("rst_mem_err", {31'b0, ifa.mem_err}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #3;
    chk("init_pc_write", {31'b0, ifa.pc_write}, 32'd1);
    chk("init_ifid_write", {31'b0, ifa.ifid_write}, 32'd1);
    chk("init_idex_write", {31'b0, ifa.idex_write}, 32'd1);
    chk("init_exmem_hold", {31'b0, ifa.exmem_hold}, 32'd0);
    chk("init_stall_cnt", {16'b0, ifa.stall_cnt}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Load-use on rs
    apply(5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("lu_pc_write", {31'b0, ifa.pc_write}, 32'd0);
    chk("lu_ifid_write", {31'b0, ifa.ifid_write}, 32'd0);
    chk("lu_idex_bubble", {31'b0, ifa.idex_bubble}, 32'd1);
    idle();
    chk("lu_release", {31'b0, ifa.pc_write}, 32'd1);
    chk("lu_stall_cnt", {16'b0, ifa.stall_cnt}, PERF);

    // No stall on $0 or an unused rt; stall when rt is used
    apply(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("lu_r0", {31'b0, ifa.pc_write}, 32'd1);
    apply(5'd1, 5'd9, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("lu_rt_unused", {31'b0, ifa.pc_write}, 32'd1);
    apply(5'd1, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("lu_rt_used", {31'b0, ifa.pc_write}, 32'd0);
    idle();

    // Taken branch: A flushes 2 cycles, B 3 cycles
    apply(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("br_flush", {31'b0, ifa.ifid_flush}, 32'd1);
    chk("br_bubble", {31'b0, ifa.idex_bubble}, 32'd1);
    chk("br_pc_write", {31'b0, ifa.pc_write}, 32'd1);
    idle();
    chk("br_flush2", {31'b0, ifa.ifid_flush}, 32'd1);
    idle();
    chk("br_done_a", {31'b0, ifa.ifid_flush}, 32'd0);
    chk("br_flush3_b", {31'b0, ifb.ifid_flush}, 32'd1);
    idle();
    chk("br_done_b", {31'b0, ifb.ifid_flush}, 32'd0);
    chk("br_flush_cnt_a", {16'b0, ifa.flush_cnt}, 2 * PERF);

    // Branch and load-use together: flush wins
    apply(5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("br_lu_pc_write", {31'b0, ifa.pc_write}, 32'd1);
    chk("br_lu_flush", {31'b0, ifa.ifid_flush}, 32'd1);
    repeat (3) idle();

    // Mem wait for 3 cycles inside B's flush, then resume
    apply(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      apply(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("mw_hold", {31'b0, ifb.exmem_hold}, 32'd1);
      chk("mw_no_flush", {31'b0, ifb.ifid_flush}, 32'd0);
      chk("mw_pc_write", {31'b0, ifb.pc_write}, 32'd0);
    end
    apply(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("mw_ready_hold", {31'b0, ifb.exmem_hold}, 32'd0);
    idle();
    chk("mw_resume1", {31'b0, ifb.ifid_flush}, 32'd1);
    idle();
    chk("mw_resume2", {31'b0, ifb.ifid_flush}, 32'd1);
    idle();
    chk("mw_resume_end", {31'b0, ifb.ifid_flush}, 32'd0);

    // Timeout with MEM_TIMEOUT=4: error after the 5th wait cycle
    for (int i = 0; i < 5; i++) begin
      apply(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("to_err_pending", {31'b0, ifa.mem_err}, 32'd0);
    end
    idle();
    chk("to_err_set", {31'b0, ifa.mem_err}, 32'd1);
    chk("to_err_pc", {31'b0, ifa.pc_write}, 32'd0);
    chk("to_err_hold", {31'b0, ifa.exmem_hold}, 32'd1);
    apply(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("to_err_sticky", {31'b0, ifb.mem_err}, 32'd1);
    reset_now();

    // Async reset in the middle of B's flush
    apply(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle();
    chk("rstf_flushing", {31'b0, ifb.ifid_flush}, 32'd1);
    reset_now();
    idle();
    chk("rstf_after", {31'b0, ifb.ifid_flush}, 32'd0);

    // Counter saturation on the 4-bit instance
    repeat (20) apply(5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    idle();
    chk("sat_stall_b", {16'b0, got_st[1]}, 15 * PERF);
    repeat (20) apply(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle();
    chk("sat_flush_b", {16'b0, got_fl[1]}, 15 * PERF);
    repeat (4) idle();

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
